// File: rtl/button_conditioner.sv
// Six-button synchroniser, per-bit debouncer and press-pulse generator.
// Optional up/down auto-repeat is built only when BTN_REPEAT_EN is defined.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] btn_n_i,
  output logic [5:0] press_o,
  output logic [5:0] held_o,
  output logic       any_o
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [5:0]       sync1_q, sync2_q;
  logic [5:0]       lvl;
  logic [5:0]       held_q, held_d;
  logic [5:0]       held_dly_q;
  logic [CNT_W-1:0] cnt_q [6];
  logic [CNT_W-1:0] cnt_d [6];
  logic [5:0]       rising;
  logic [5:0]       press_q, press_d;
  logic             any_q, any_d;

  // Synchroniser resets to "released" so a button held through reset counts as a new press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign lvl = ~sync2_q;

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      held_d[i] = held_q[i];
      cnt_d[i]  = '0;
      if (lvl[i] != held_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          held_d[i] = lvl[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q     <= '0;
      held_dly_q <= '0;
      for (int i = 0; i < 6; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      held_q     <= held_d;
      held_dly_q <= held_q;
      for (int i = 0; i < 6; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rising = held_q & ~held_dly_q;

`ifdef BTN_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  logic [RPT_W-1:0] rpt_cnt_q [2];
  logic [RPT_W-1:0] rpt_cnt_d [2];
  logic [1:0]       rpt_arm_q, rpt_arm_d;
  logic [1:0]       rpt_fire;

  // Counting starts the cycle after the initial pulse; arm selects delay vs. rate period.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rpt_cnt_d[i] = rpt_cnt_q[i];
      rpt_arm_d[i] = rpt_arm_q[i];
      rpt_fire[i]  = 1'b0;
      if (!held_q[i]) begin
        rpt_cnt_d[i] = '0;
        rpt_arm_d[i] = 1'b0;
      end else if (held_dly_q[i]) begin
        if (rpt_cnt_q[i] == (rpt_arm_q[i] ? RATE_LAST : DELAY_LAST)) begin
          rpt_fire[i]  = 1'b1;
          rpt_cnt_d[i] = '0;
          rpt_arm_d[i] = 1'b1;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_arm_q <= '0;
      for (int i = 0; i < 2; i++) begin
        rpt_cnt_q[i] <= '0;
      end
    end else begin
      rpt_arm_q <= rpt_arm_d;
      for (int i = 0; i < 2; i++) begin
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
    end
  end

  assign press_d = rising | {4'b0000, rpt_fire};
`else
  assign press_d = rising;
`endif

  assign any_d = |press_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q <= '0;
      any_q   <= 1'b0;
    end else begin
      press_q <= press_d;
      any_q   <= any_d;
    end
  end

  assign press_o = press_q;
  assign held_o  = held_q;
  assign any_o   = any_q;

endmodule
